// File: rtl/d_to_jk_reg.sv
// d_to_jk_reg: multi-bit JK register built on D flip-flops, with commands queued in a valid/ready FIFO.
// Optional feature: define TOGGLE_CNT_EN to add the saturating toggle_cnt output (count of q bit flips).
module d_to_jk_reg #(
    parameter int WIDTH      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             busy
`ifdef TOGGLE_CNT_EN
    ,
    output logic [15:0]      toggle_cnt
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] j_mem [FIFO_DEPTH];
    logic [WIDTH-1:0] k_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] head_j, head_k;
    logic             push, pop;

    assign head_j    = j_mem[rd_q];
    assign head_k    = k_mem[rd_q];
    assign cmd_ready = ready_q;
    assign busy      = (cnt_q != '0);
    assign q         = state_q;
    assign qbar      = ~state_q;

    // Handshake, pointer/occupancy bookkeeping and JK-to-D excitation of the head command.
    always_comb begin
        push    = cmd_valid & ready_q;
        pop     = (cnt_q != '0);
        wr_d    = push ? wr_q + PTR_ONE : wr_q;
        rd_d    = pop ? rd_q + PTR_ONE : rd_q;
        cnt_d   = cnt_q + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
        ready_d = (cnt_d != FULL_CNT);
        state_d = pop ? ((head_j & ~state_q) | (~head_k & state_q)) : state_q;
    end

    // Command storage; stale entries are harmless because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            j_mem[wr_q] <= j;
            k_mem[wr_q] <= k;
        end
    end

    // State, pointers and registered ready; reset drops queued commands without applying them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            state_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            state_q <= state_d;
        end
    end

`ifdef TOGGLE_CNT_EN
    logic [15:0] tcnt_q, tcnt_d, flips;
    logic [16:0] tsum;

    // Popcount of the bits that change on this edge, added with saturation at all ones.
    always_comb begin
        flips = '0;
        for (int i = 0; i < WIDTH; i++) flips = flips + 16'(state_d[i] ^ state_q[i]);
        tsum   = {1'b0, tcnt_q} + {1'b0, flips};
        tcnt_d = tsum[16] ? 16'hFFFF : tsum[15:0];
    end

    // Toggle counter register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tcnt_q <= '0;
        else     tcnt_q <= tcnt_d;
    end

    assign toggle_cnt = tcnt_q;
`endif

endmodule

// File: tb/tb_d_to_jk_reg.sv
// tb_d_to_jk_reg: randomized and directed checks of d_to_jk_reg against a queue-based JK model.
module tb_d_to_jk_reg;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] j = '0;
    logic [3:0] k = '0;
    logic [3:0] q, qbar;
    logic       busy;
`ifdef TOGGLE_CNT_EN
    logic [15:0] toggle_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic [3:0] m_q = '0;
    int         m_tc = 0;
    int         acc_cnt = 0;

    always #5 clk = ~clk;

    d_to_jk_reg #(.WIDTH(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .j(j),
        .k(k),
        .q(q),
        .qbar(qbar),
        .busy(busy)
`ifdef TOGGLE_CNT_EN
        ,
        .toggle_cnt(toggle_cnt)
`endif
    );

    function automatic logic [3:0] jk_apply(input logic [3:0] cur, input logic [3:0] jj, input logic [3:0] kk);
        logic [3:0] nxt;
        for (int i = 0; i < 4; i++) begin
            case ({jj[i], kk[i]})
                2'b00:   nxt[i] = cur[i];
                2'b01:   nxt[i] = 1'b0;
                2'b10:   nxt[i] = 1'b1;
                default: nxt[i] = ~cur[i];
            endcase
        end
        return nxt;
    endfunction

    function automatic logic m_ready();
        return mq.size() < DEPTH;
    endfunction

    // One clock of stimulus starting just after a falling edge; model advances at the rising edge.
    task automatic cycle(input logic v, input logic [3:0] jj, input logic [3:0] kk);
        logic       acc;
        logic [7:0] head;
        logic [3:0] nq;
        cmd_valid = v;
        j = jj;
        k = kk;
        acc = v && m_ready();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_q = '0;
            m_tc = 0;
        end else begin
            if (mq.size() > 0) begin
                head = mq.pop_front();
                nq = jk_apply(m_q, head[7:4], head[3:0]);
                m_tc = m_tc + $countones(nq ^ m_q);
                if (m_tc > 65535) m_tc = 65535;
                m_q = nq;
            end
            if (acc) begin
                mq.push_back({jj, kk});
                acc_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 4'h0, 4'h0);
        cycle(1'b0, 4'h0, 4'h0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset();
        checks++; if (q !== 4'b0000) begin errors++; $display("FAIL reset_q got=%b exp=0000", q); end
        checks++; if (qbar !== 4'b1111) begin errors++; $display("FAIL reset_qbar got=%b exp=1111", qbar); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef TOGGLE_CNT_EN
        checks++; if (toggle_cnt !== 16'd0) begin errors++; $display("FAIL reset_tcnt got=%0d exp=0", toggle_cnt); end
`endif
    endtask

    task automatic test_single();
        cycle(1'b1, 4'b1010, 4'b0000);
        checks++; if (q !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL single_latency q=%b busy=%b exp q=0000 busy=1", q, busy); end
        cycle(1'b0, 4'h0, 4'h0);
        checks++; if (q !== 4'b1010 || busy !== 1'b0) begin errors++; $display("FAIL single_set q=%b busy=%b exp q=1010 busy=0", q, busy); end
        cycle(1'b1, 4'b1111, 4'b1111);
        cycle(1'b0, 4'h0, 4'h0);
        checks++; if (q !== 4'b0101 || qbar !== 4'b1010) begin errors++; $display("FAIL single_toggle q=%b qbar=%b exp 0101/1010", q, qbar); end
    endtask

    task automatic test_mixed();
        cycle(1'b1, 4'b1001, 4'b0110);
        cycle(1'b0, 4'h0, 4'h0);
        checks++; if (q !== 4'b1001 || q !== m_q) begin errors++; $display("FAIL mixed q=%b exp=1001 model=%b", q, m_q); end
    endtask

    task automatic test_back_pressure();
        int start;
        do_reset();
        start = acc_cnt;
        for (int c = 0; c < 8; c++) begin
            cycle(1'b1, 4'b1111, 4'b1111);
            checks++; if (cmd_ready !== m_ready() || q !== m_q) begin errors++; $display("FAIL bp_cycle%0d ready=%b q=%b exp ready=%b q=%b", c, cmd_ready, q, m_ready(), m_q); end
        end
        for (int c = 0; c < DEPTH + 1; c++) cycle(1'b0, 4'h0, 4'h0);
        checks++; if (q !== (((acc_cnt - start) % 2) ? 4'b1111 : 4'b0000) || busy !== 1'b0) begin errors++; $display("FAIL bp_final q=%b busy=%b accepted=%0d", q, busy, acc_cnt - start); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
            checks++;
            if (q !== m_q || qbar !== ~m_q || cmd_ready !== m_ready() || busy !== (mq.size() > 0)) begin
                errors++;
                $display("FAIL rand_cycle%0d q=%b qbar=%b ready=%b busy=%b exp q=%b ready=%b busy=%b", c, q, qbar, cmd_ready, busy, m_q, m_ready(), mq.size() > 0);
            end
`ifdef TOGGLE_CNT_EN
            checks++; if (toggle_cnt !== 16'(m_tc)) begin errors++; $display("FAIL rand_tcnt%0d got=%0d exp=%0d", c, toggle_cnt, m_tc); end
`endif
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        cycle(1'b1, 4'b1111, 4'b0000);
        cycle(1'b1, 4'b1111, 4'b0000);
        cycle(1'b1, 4'b1111, 4'b0000);
        cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (q !== 4'b0000 || qbar !== 4'b1111) begin errors++; $display("FAIL async_rst q=%b qbar=%b exp 0000/1111", q, qbar); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL async_rst_flags busy=%b ready=%b exp 0/1", busy, cmd_ready); end
        @(negedge clk);
        cycle(1'b0, 4'h0, 4'h0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 4'h0, 4'h0);
            checks++; if (q !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL post_rst%0d q=%b busy=%b exp 0000/0", c, q, busy); end
        end
    endtask

`ifdef TOGGLE_CNT_EN
    task automatic test_toggle_cnt();
        do_reset();
        for (int c = 0; c < 5; c++) cycle(1'b1, 4'b1111, 4'b1111);
        cycle(1'b0, 4'h0, 4'h0);
        checks++; if (toggle_cnt !== 16'd20 || m_tc != 20) begin errors++; $display("FAIL tcnt_five got=%0d exp=20", toggle_cnt); end
        for (int c = 0; c < 16390; c++) cycle(1'b1, 4'b1111, 4'b1111);
        cycle(1'b0, 4'h0, 4'h0);
        checks++; if (toggle_cnt !== 16'hFFFF) begin errors++; $display("FAIL tcnt_sat got=%h exp=ffff", toggle_cnt); end
        cycle(1'b1, 4'b1111, 4'b1111);
        cycle(1'b0, 4'h0, 4'h0);
        checks++; if (toggle_cnt !== 16'hFFFF || q !== m_q) begin errors++; $display("FAIL tcnt_hold got=%h q=%b exp=ffff q=%b", toggle_cnt, q, m_q); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_mixed();
        test_back_pressure();
        test_random();
        test_reset_mid_burst();
`ifdef TOGGLE_CNT_EN
        test_toggle_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
